// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin two-requester UART transmit framer paced by an external baud tick
module uart_tx_scheduler #(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              BAUD_TICK,
    input  logic              REQ0_VALID,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,
    output logic              TX,
    output logic              BUSY,
    output logic              GRANT,
    output logic              FRAME_DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] BIT_LAST  = 4'(DATA_W - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2);
    localparam logic       PAR_EN    = (PARITY_EN != 0);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);

    state_t            state, state_nx;
    logic [DATA_W-1:0] shift_q, shift_nx;
    logic [3:0]        bit_cnt, bit_cnt_nx;
    logic              stop_cnt, stop_cnt_nx;
    logic              tx_q, tx_nx;
    logic              grant_q, grant_nx;
    logic              last_grant, last_grant_nx;
    logic              parity_q, parity_nx;
    logic              done_q, done_nx;

    logic              idle;
    logic              take0;
    logic              take1;
    logic [DATA_W-1:0] sel_data;

    // last_grant resets to 1 so requester 0 wins the very first tie
    assign idle     = (state == S_IDLE);
    assign take0    = idle & REQ0_VALID & (~REQ1_VALID | last_grant);
    assign take1    = idle & REQ1_VALID & (~REQ0_VALID | ~last_grant);
    assign sel_data = take1 ? REQ1_DATA : REQ0_DATA;

    assign REQ0_READY = take0;
    assign REQ1_READY = take1;
    assign TX         = tx_q;
    assign BUSY       = ~idle;
    assign GRANT      = grant_q;
    assign FRAME_DONE = done_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx_q       <= 1'b1;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            parity_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_q    <= shift_nx;
            bit_cnt    <= bit_cnt_nx;
            stop_cnt   <= stop_cnt_nx;
            tx_q       <= tx_nx;
            grant_q    <= grant_nx;
            last_grant <= last_grant_nx;
            parity_q   <= parity_nx;
            done_q     <= done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        shift_nx      = shift_q;
        bit_cnt_nx    = bit_cnt;
        stop_cnt_nx   = stop_cnt;
        tx_nx         = tx_q;
        grant_nx      = grant_q;
        last_grant_nx = last_grant;
        parity_nx     = parity_q;
        done_nx       = 1'b0;

        unique case (state)
            S_IDLE: begin
                // the baud tick is deliberately not looked at here, even on the accept cycle
                if (take0 | take1) begin
                    shift_nx      = sel_data;
                    grant_nx      = take1;
                    last_grant_nx = take1;
                    parity_nx     = (^sel_data) ^ PAR_ODD;
                    state_nx      = S_ARM;
                end
            end
            S_ARM: begin
                if (BAUD_TICK) begin
                    tx_nx    = 1'b0;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (BAUD_TICK) begin
                    tx_nx      = shift_q[0];
                    bit_cnt_nx = '0;
                    state_nx   = S_DATA;
                end
            end
            S_DATA: begin
                if (BAUD_TICK) begin
                    shift_nx   = shift_q >> 1;
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == BIT_LAST) begin
                        if (PAR_EN) begin
                            tx_nx    = parity_q;
                            state_nx = S_PARITY;
                        end else begin
                            tx_nx       = 1'b1;
                            stop_cnt_nx = 1'b0;
                            state_nx    = S_STOP;
                        end
                    end else begin
                        tx_nx = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (BAUD_TICK) begin
                    tx_nx       = 1'b1;
                    stop_cnt_nx = 1'b0;
                    state_nx    = S_STOP;
                end
            end
            S_STOP: begin
                if (BAUD_TICK) begin
                    if (stop_cnt == STOP_LAST) begin
                        done_nx  = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        stop_cnt_nx = 1'b1;
                    end
                end
            end
            default: begin
                tx_nx    = 1'b1;
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmit line between two byte requesters using round-robin arbitration. Serialises each granted byte as a start/data/parity/stop frame, paced by the single-cycle baud tick from the clock divider. Sits between the divider output and the TX pin. Owns all frame sequencing, so requesters need only a valid/ready handshake.

Parameters:
DATA_W, 8, data bits per frame (5..9), sent LSB first
STOP_BITS, 1, number of stop bits (1 or 2)
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1)

Ports:
CLK  input  1  system clock; all logic on posedge
RST_N  input  1  asynchronous active-low reset
BAUD_TICK  input  1  one-CLK-wide pulse, once per bit period
REQ0_VALID  input  1  requester 0 has a byte
REQ0_DATA  input  DATA_W  requester 0 byte
REQ0_READY  output  1  requester 0 byte accepted this cycle
REQ1_VALID  input  1  requester 1 has a byte
REQ1_DATA  input  DATA_W  requester 1 byte
REQ1_READY  output  1  requester 1 byte accepted this cycle
TX  output  1  serial line, idle high, registered
BUSY  output  1  frame in progress (state != IDLE)
GRANT  output  1  requester that owns the current/last frame
FRAME_DONE  output  1  one-cycle pulse when the final stop bit ends

Behaviour:
- Reset (async, RST_N=0): state=IDLE, TX=1, BUSY=0, GRANT=0, FRAME_DONE=0, last_grant=1 (requester 0 wins the first tie), shift/bit/stop counters=0. Reset mid-frame aborts the frame; TX goes high immediately.
- READY outputs are combinational and asserted only in IDLE:
  - REQ0_READY = IDLE & REQ0_VALID & (!REQ1_VALID | last_grant==1)
  - REQ1_READY = IDLE & REQ1_VALID & (!REQ0_VALID | last_grant==0)
  - At most one READY is high in any cycle.
- Transfer occurs when VALID & READY. In that cycle: latch DATA into the shift register, set GRANT and last_grant to the winner, state goes to ARM.
- VALID held while BUSY is ignored; no data is sampled until the next IDLE.
- BAUD_TICK is ignored in IDLE, including in the accept cycle.
- States and transitions (each transition happens only on a cycle with BAUD_TICK=1; TX updates in that same registered edge):
  - ARM -> START: TX=0.
  - START -> DATA: TX=shift[0], bit_cnt=0.
  - DATA: on tick, shift right and bit_cnt++. When bit_cnt==DATA_W-1, go to PARITY (TX=parity) if PARITY_EN, else STOP (TX=1).
  - PARITY -> STOP: TX=1, stop_cnt=0.
  - STOP: on tick, if stop_cnt==STOP_BITS-1, go to IDLE and pulse FRAME_DONE for one cycle; else stop_cnt++.
- Parity = XOR of the latched byte, inverted when PARITY_ODD=1.
- Timing: each bit is held exactly one tick interval. Frame length is 1+DATA_W+PARITY_EN+STOP_BITS tick intervals, measured from the start bit's tick.
- Back-to-back frames: accept occurs in the IDLE cycle after FRAME_DONE, and the start bit waits for the next tick. The line therefore stays high at least one extra bit period between frames. This gap is required behaviour.
- Requesters are never starved: with both VALID held, grants alternate 0,1,0,1...
- GRANT holds its value after the frame until the next accept.

Test Plan:
- Single byte: REQ0 sends 0xA5, ticks every 16 CLK, 8N1 -> TX per tick = 0,1,0,1,0,0,1,0,1,1. FRAME_DONE pulses once. REQ0_READY is high for exactly 1 cycle. BUSY spans 10 tick intervals plus ARM wait.
- Arbitration: both VALID held from reset with REQ0=0x11, REQ1=0x22 -> grant order 0,1,0,1. GRANT matches each frame. No READY is asserted while BUSY. Line is high ≥1 bit period between frames.
- Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame is 11 tick intervals.
- Two stop bits: STOP_BITS=2, byte 0x00 -> after 8 zero data bits, TX high for 2 tick intervals, then FRAME_DONE.
- Reset mid-frame: assert RST_N=0 during data bit 3 -> TX=1 and BUSY=0 asynchronously. After release, both requesters VALID -> requester 0 is granted first.
- Tick on accept cycle: BAUD_TICK coincides with the handshake -> the tick is ignored and the start bit begins at the following tick.
